// File: rtl/alu_stream_if.sv
// Valid/ready bundle between the ALU stream core and its driver/consumer.
interface alu_stream_if #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OP_W-1:0]  op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero, err
    );
endinterface

// File: rtl/alu_stream_core.sv
// Two-stage valid/ready ALU: stage1 holds operands, stage2 holds result and flags.
module alu_stream_core #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
) (
    input logic         clk,
    input logic         rst,
    alu_stream_if.slave io
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
    localparam logic [OP_W-1:0] OP_NOT = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SHL = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SHR = OP_W'(7);
    localparam logic [OP_W-1:0] OP_INC = OP_W'(8);
    localparam logic [OP_W-1:0] OP_DEC = OP_W'(9);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [OP_W-1:0]  s1_op_q, s1_op_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic             advance;
    logic             in_ready;
    logic [WIDTH-1:0] rhs;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH-1:0] res_c;
    logic             carry_c, ovf_c, err_c;

    assign advance  = !s2_valid_q || io.out_ready;
    assign in_ready = !s1_valid_q || advance;

    // INC/DEC reuse the adder/subtractor with an implicit operand of 1
    always_comb begin
        rhs = s1_b_q;
        if (s1_op_q == OP_INC || s1_op_q == OP_DEC) rhs = WIDTH'(1);
        sum = {1'b0, s1_a_q} + {1'b0, rhs};
        dif = {1'b0, s1_a_q} - {1'b0, rhs};
    end

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        err_c   = 1'b0;
        case (s1_op_q)
            OP_ADD, OP_INC: begin
                res_c   = sum[WIDTH-1:0];
                carry_c = sum[WIDTH];
                ovf_c   = (s1_a_q[WIDTH-1] == rhs[WIDTH-1]) &&
                          (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_SUB, OP_DEC: begin
                res_c   = dif[WIDTH-1:0];
                carry_c = dif[WIDTH];
                ovf_c   = (s1_a_q[WIDTH-1] != rhs[WIDTH-1]) &&
                          (dif[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_AND:  res_c = s1_a_q & s1_b_q;
            OP_OR:   res_c = s1_a_q | s1_b_q;
            OP_XOR:  res_c = s1_a_q ^ s1_b_q;
            OP_NOT:  res_c = ~s1_a_q;
            OP_SHL:  res_c = s1_a_q << s1_b_q[SH_W-1:0];
            OP_SHR:  res_c = s1_a_q >> s1_b_q[SH_W-1:0];
            default: err_c = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        err_d      = err_q;
        if (in_ready) begin
            s1_valid_d = io.in_valid;
            if (io.in_valid) begin
                s1_a_d  = io.a;
                s1_b_d  = io.b;
                s1_op_d = io.op;
            end
        end
        // Flags hold their last values when stage2 drains empty
        if (advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = res_c;
                carry_d  = carry_c;
                ovf_d    = ovf_c;
                zero_d   = (res_c == '0);
                err_d    = err_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
            err_q      <= err_d;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = s2_valid_q;
    assign io.result    = result_q;
    assign io.carry     = carry_q;
    assign io.overflow  = ovf_q;
    assign io.zero      = zero_q;
    assign io.err       = err_q;
endmodule

// File: tb/tb_alu_stream_core.sv
// Bench for alu_stream_core: directed corner cases plus a randomized
// stream checked against an arithmetic reference queue.
module tb_alu_stream_core;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   pops = 0;

    logic [11:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [11:0] prev_out;
    logic        acc;

    alu_stream_if #(.WIDTH(W), .OP_W(4)) io ();

    alu_stream_core #(.WIDTH(W), .OP_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model(
        input logic [7:0] a_i,
        input logic [7:0] b_i,
        input logic [3:0] op_i
    );
        int ua = int'(a_i);
        int ub = int'(b_i);
        int sa = int'($signed(a_i));
        int sb = int'($signed(b_i));
        int s  = 0;
        int ss = 0;
        logic [7:0] r = 8'h00;
        logic c = 1'b0;
        logic v = 1'b0;
        logic e = 1'b0;
        logic arith = 1'b0;
        case (op_i)
            4'd0: begin s = ua + ub; ss = sa + sb; arith = 1'b1; end
            4'd1: begin s = ua - ub; ss = sa - sb; arith = 1'b1; end
            4'd8: begin s = ua + 1;  ss = sa + 1;  arith = 1'b1; end
            4'd9: begin s = ua - 1;  ss = sa - 1;  arith = 1'b1; end
            4'd2: r = a_i & b_i;
            4'd3: r = a_i | b_i;
            4'd4: r = a_i ^ b_i;
            4'd5: r = ~a_i;
            4'd6: r = 8'((ua * (1 << (ub % 8))) % 256);
            4'd7: r = 8'(ua / (1 << (ub % 8)));
            default: e = 1'b1;
        endcase
        if (arith) begin
            r = 8'((s + 512) % 256);
            c = (s > 255) || (s < 0);
            v = (ss > 127) || (ss < -128);
        end
        return {r, c, v, (r == 8'h00), e};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: records transfers that complete at the following rising edge
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(io.out_valid), 32'd1);
                check("stall_stable",
                      32'({io.result, io.carry, io.overflow, io.zero, io.err}),
                      32'(prev_out));
            end
            if (io.out_valid && io.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    check("stream_out",
                          32'({io.result, io.carry, io.overflow, io.zero, io.err}),
                          32'(exp_q.pop_front()));
                    pops++;
                end
            end
            if (io.in_valid && io.in_ready)
                exp_q.push_back(model(io.a, io.b, io.op));
            prev_stall <= io.out_valid && !io.out_ready;
            prev_out   <= {io.result, io.carry, io.overflow, io.zero, io.err};
        end
    end

    task automatic send(input logic [7:0] a_i, input logic [7:0] b_i, input logic [3:0] op_i);
        int  n = 0;
        bit  done = 0;
        io.in_valid = 1'b1;
        io.a = a_i;
        io.b = b_i;
        io.op = op_i;
        while (!done && n < 50) begin
            @(negedge clk);
            done = io.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        io.in_valid = 1'b0;
        check("send_accept", 32'(done), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        io.out_ready = 1'b1;
        while ((exp_q.size() != 0 || io.out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_out(input string tag, input logic [11:0] exp);
        check({tag, "_valid"}, 32'(io.out_valid), 32'd1);
        check(tag, 32'({io.result, io.carry, io.overflow, io.zero, io.err}), 32'(exp));
    endtask

    initial begin
        io.in_valid  = 1'b0;
        io.a         = '0;
        io.b         = '0;
        io.op        = '0;
        io.out_ready = 1'b1;
        acc          = 1'b0;
        #1;
        check("rst_out_valid", 32'(io.out_valid), 32'd0);
        check("rst_outputs",
              32'({io.result, io.carry, io.overflow, io.zero, io.err}), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(io.in_ready), 32'd1);

        // Directed corner cases, out_ready held high
        send(8'hFF, 8'h01, 4'd0);
        @(posedge clk); #1;
        check_out("add_ff_01", {8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
        send(8'h7F, 8'h01, 4'd0);
        @(posedge clk); #1;
        check_out("add_7f_01", {8'h80, 1'b0, 1'b1, 1'b0, 1'b0});
        send(8'h00, 8'h01, 4'd1);
        @(posedge clk); #1;
        check_out("sub_00_01", {8'hFF, 1'b1, 1'b0, 1'b0, 1'b0});
        send(8'h55, 8'h00, 4'hC);
        @(posedge clk); #1;
        check_out("illegal_c", {8'h00, 1'b0, 1'b0, 1'b1, 1'b1});
        send(8'h81, 8'h09, 4'd6);
        @(posedge clk); #1;
        check_out("shl_81_09", {8'h02, 1'b0, 1'b0, 1'b0, 1'b0});
        send(8'h80, 8'h00, 4'd9);
        @(posedge clk); #1;
        check_out("dec_80", {8'h7F, 1'b0, 1'b1, 1'b0, 1'b0});
        drain();

        // Back-to-back stream of 20 ops
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            io.in_valid = 1'b1;
            io.a  = 8'($urandom);
            io.b  = 8'($urandom);
            io.op = 4'($urandom_range(0, 9));
            @(negedge clk);
            check("b2b_in_ready", 32'(io.in_ready), 32'd1);
            @(posedge clk); #1;
        end
        io.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("b2b_count", 32'(pops), 32'd20);
        drain();

        // Backpressure: two ops fill the pipe, third waits
        pops = 0;
        io.out_ready = 1'b0;
        send(8'h10, 8'h20, 4'd0);
        send(8'h33, 8'h0F, 4'd2);
        io.in_valid = 1'b1;
        io.a = 8'hA5;
        io.b = 8'h03;
        io.op = 4'd7;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(io.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("bp_head", 32'(io.result), 32'h30);
        io.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(io.in_ready), 32'd1);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        drain();
        check("bp_count", 32'(pops), 32'd3);

        // Async reset with two ops in flight
        io.out_ready = 1'b0;
        send(8'h01, 8'h02, 4'd0);
        send(8'h03, 8'h04, 4'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(io.out_valid), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        io.out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("post_rst_empty", 32'(io.out_valid), 32'd0);
        end

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            io.out_ready = ($urandom_range(0, 3) != 0);
            if (!io.in_valid || acc) begin
                io.in_valid = 1'($urandom_range(0, 1));
                io.a  = 8'($urandom);
                io.b  = 8'($urandom);
                io.op = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            acc = io.in_valid && io.in_ready;
            @(posedge clk); #1;
        end
        io.in_valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
